clk_div_bank: RTL and testbench

- Parametrised successor to the fixed-ratio clock manager. Generates NUM_CH independent divided clocks and one-cycle strobes from sys_clk for the oscilloscope's ADC sampling and timebase logic.
- Each channel's ratio is reprogrammed at run time through a valid/ready config port. A new ratio takes effect glitch-free on that channel's next wrap.
- A global sync pulse phase-aligns all enabled channels.

---
 rtl/clk_div_bank_if.sv | 34 +++
 rtl/clk_div_bank.sv | 156 +++++++++++++++
 tb/tb_clk_div_bank.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// -----------------------------------------------------------------------------
// clk_div_bank_if
// Purpose : valid/ready configuration port of clk_div_bank. One request carries
//           a target channel and a new divide ratio.
// Signals : cfg_valid  request valid (master -> slave)
//           cfg_ready  pending slot free (slave -> master)
//           cfg_ch     target channel, CH_W bits
//           cfg_div    new divide ratio, DIV_W bits (0 is treated as 1)
// -----------------------------------------------------------------------------
interface clk_div_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Purpose : NUM_CH independent clock dividers running off sys_clk. Each channel
//           produces a registered divided clock (high ceil(D/2), low floor(D/2))
//           and a one-cycle strobe per period. Ratios are reprogrammed at run
//           time through a single-slot config port; a new ratio is applied on
//           the target channel's next wrap (or sync edge, or at once if the
//           channel is disabled), so no short or long pulse is ever produced.
// Ports   : sys_clk   clock, rising edge
//           rst_n     asynchronous active-low reset
//           ch_en     per-channel run enable
//           sync_req  one-cycle pulse, forces a wrap on every enabled channel
//           cfg       config port (clk_div_bank_if.slave)
//           div_clk   divided clocks, straight from flops
//           div_stb   one-cycle strobes, straight from flops
// -----------------------------------------------------------------------------
module clk_div_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_req,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_stb
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DIV_W-1:0] ResetDiv = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ResetCnt = DIV_W'(RESET_DIV - 1);

  // Number of high cycles per period: ceil(d/2), cannot overflow DIV_W.
  function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] d);
    return (d >> 1) + DIV_W'(d[0]);
  endfunction

  // Per-channel state
  logic [DIV_W-1:0]  r_div [NUM_CH];
  logic [DIV_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_stb;

  // Single pending config slot
  logic              r_pend_vld;
  logic [CH_W-1:0]   r_pend_ch;
  logic [DIV_W-1:0]  r_pend_div;
  logic              r_cfg_ready;

  // Next-state
  logic [DIV_W-1:0]  w_div_d [NUM_CH];
  logic [DIV_W-1:0]  w_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] w_clk_d;
  logic [NUM_CH-1:0] w_stb_d;
  logic [NUM_CH-1:0] w_apply;
  logic              w_pend_vld_d;
  logic [CH_W-1:0]   w_pend_ch_d;
  logic [DIV_W-1:0]  w_pend_div_d;
  logic              w_accept;
  logic              w_in_range;
  logic [DIV_W-1:0]  w_new_div;

  assign w_accept   = cfg.cfg_valid & r_cfg_ready;
  assign w_in_range = (32'(cfg.cfg_ch) < NUM_CH);
  assign w_new_div  = (cfg.cfg_div == '0) ? DIV_W'(1) : cfg.cfg_div;

  // Channel datapath
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic w_tgt;
      logic w_wrap;
      w_div_d[i] = r_div[i];
      w_cnt_d[i] = r_cnt[i];
      w_clk_d[i] = 1'b0;
      w_stb_d[i] = 1'b0;
      w_apply[i] = 1'b0;
      // r_pend_vld is only set after the acceptance edge, so a request is
      // never applied on the same edge it is accepted.
      w_tgt  = r_pend_vld && (r_pend_ch == CH_W'(i));
      w_wrap = (r_cnt[i] == r_div[i] - DIV_W'(1));
      if (!ch_en[i]) begin
        // Parked one short of a wrap so the first enabled edge is a wrap.
        if (w_tgt) begin
          w_div_d[i] = r_pend_div;
          w_cnt_d[i] = r_pend_div - DIV_W'(1);
          w_apply[i] = 1'b1;
        end else begin
          w_cnt_d[i] = r_div[i] - DIV_W'(1);
        end
      end else if (w_wrap || sync_req) begin
        // cnt' = 0 is always below ceil(D/2) >= 1, so the clock goes high.
        w_cnt_d[i] = '0;
        w_clk_d[i] = 1'b1;
        w_stb_d[i] = 1'b1;
        if (w_tgt) begin
          w_div_d[i] = r_pend_div;
          w_apply[i] = 1'b1;
        end
      end else begin
        w_cnt_d[i] = r_cnt[i] + DIV_W'(1);
        w_clk_d[i] = (w_cnt_d[i] < half_up(r_div[i]));
      end
    end
  end

  // Config slot
  always_comb begin
    w_pend_vld_d = r_pend_vld;
    w_pend_ch_d  = r_pend_ch;
    w_pend_div_d = r_pend_div;
    if (r_pend_vld) begin
      if (|w_apply) begin
        w_pend_vld_d = 1'b0;
      end
    end else if (w_accept && w_in_range) begin
      w_pend_vld_d = 1'b1;
      w_pend_ch_d  = cfg.cfg_ch;
      w_pend_div_d = w_new_div;
    end
    // Out-of-range requests are consumed without touching the slot.
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= ResetDiv;
        r_cnt[i] <= ResetCnt;
      end
      r_clk       <= '0;
      r_stb       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_ch   <= '0;
      r_pend_div  <= '0;
      r_cfg_ready <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= w_div_d[i];
        r_cnt[i] <= w_cnt_d[i];
      end
      r_clk       <= w_clk_d;
      r_stb       <= w_stb_d;
      r_pend_vld  <= w_pend_vld_d;
      r_pend_ch   <= w_pend_ch_d;
      r_pend_div  <= w_pend_div_d;
      r_cfg_ready <= !w_pend_vld_d;
    end
  end

  assign div_clk       = r_clk;
  assign div_stb       = r_stb;
  assign cfg.cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Directed stimulus with hand-derived per-cycle expectations. The stimulus
// pushes the expected {div_clk, div_stb, cfg_ready} for each clock edge into a
// queue; a separate monitor pops and compares after every edge.
// NUM_CH = 5 so that a 3-bit cfg_ch can address a non-existent channel (7).
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int NCH = 5;
  localparam int DW  = 16;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] stb;
    logic           rdy;
  } exp_t;

  logic           sys_clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           sync_req;
  logic [NCH-1:0] div_clk;
  logic [NCH-1:0] div_stb;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  clk_div_bank_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg_if ();

  clk_div_bank #(
    .NUM_CH   (NCH),
    .DIV_W    (DW),
    .RESET_DIV(2)
  ) u_dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .sync_req(sync_req),
    .cfg     (cfg_if.slave),
    .div_clk (div_clk),
    .div_stb (div_stb)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic compare(input string nm, input exp_t e);
    n_chk++;
    if (div_clk !== e.clk || div_stb !== e.stb || cfg_if.cfg_ready !== e.rdy) begin
      n_fail++;
      $display("FAIL %s @%0t: got div_clk=%b div_stb=%b cfg_ready=%b, want div_clk=%b div_stb=%b cfg_ready=%b",
               nm, $time, div_clk, div_stb, cfg_if.cfg_ready, e.clk, e.stb, e.rdy);
    end
  endtask

  // Monitor: one expectation per edge, sampled mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge sys_clk);
      #4;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, e);
      end
    end
  end

  // Queue the expected outputs after the next edge, then take that edge.
  task automatic cyc(input string nm, input logic [NCH-1:0] c, input logic [NCH-1:0] s,
                     input logic r);
    exp_t e;
    e.clk = c;
    e.stb = s;
    e.rdy = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic hi(input int idx, input int d);
    return idx < (d + 1) / 2;
  endfunction

  task automatic cfg_set(input logic v, input int ch, input int dv);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_div   = 16'(dv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] c, s;
    exp_t z;
    int p0, p3;
    z.clk = '0;
    z.stb = '0;
    z.rdy = 1'b1;

    rst_n    = 1'b1;
    ch_en    = '0;
    sync_req = 1'b0;
    cfg_set(1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1 compare("reset_state", z);
    #1 rst_n = 1'b1;

    // T1: channel 0 at reset ratio 2
    ch_en = 5'b00001;
    for (int k = 0; k < 12; k++) begin
      c = '0; c[0] = (k % 2 == 0);
      cyc("t1_div2", c, c, 1'b1);
    end

    // T2: channel 1, 2 -> 5 mid-period
    ch_en = 5'b00010;
    cyc("t2_first_en", 5'b00010, 5'b00010, 1'b1);
    cfg_set(1'b1, 1, 5);
    cyc("t2_accept", 5'b00000, 5'b00000, 1'b0);
    cfg_set(1'b0, 0, 0);
    cyc("t2_apply_wrap", 5'b00010, 5'b00010, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      c = '0; s = '0;
      c[1] = hi(k % 5, 5);
      s[1] = (k % 5 == 0);
      cyc("t2_div5", c, s, 1'b1);
    end

    // T3: channel 2 ratio 0 (-> 1), then 1, then an out-of-range request
    ch_en = 5'b00000;
    cfg_set(1'b1, 2, 0);
    cyc("t3_accept_d0", 5'b00000, 5'b00000, 1'b0);
    cfg_set(1'b0, 0, 0);
    cyc("t3_apply_disabled", 5'b00000, 5'b00000, 1'b1);
    ch_en = 5'b00100;
    for (int k = 0; k < 4; k++) cyc("t3_d1_from0", 5'b00100, 5'b00100, 1'b1);
    cfg_set(1'b1, 2, 1);
    cyc("t3_accept_d1", 5'b00100, 5'b00100, 1'b0);
    cfg_set(1'b0, 0, 0);
    cyc("t3_apply_d1", 5'b00100, 5'b00100, 1'b1);
    for (int k = 0; k < 3; k++) cyc("t3_d1", 5'b00100, 5'b00100, 1'b1);
    cfg_set(1'b1, 7, 9);
    cyc("t3_oob_consumed", 5'b00100, 5'b00100, 1'b1);
    cfg_set(1'b0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("t3_oob_no_change", 5'b00100, 5'b00100, 1'b1);

    // T4: ch0 at 3, ch3 at 7, arbitrary phase, then sync
    ch_en = 5'b00000;
    cfg_set(1'b1, 0, 3);
    cyc("t4_accept_ch0", 5'b00000, 5'b00000, 1'b0);
    cfg_set(1'b0, 0, 0);
    cyc("t4_apply_ch0", 5'b00000, 5'b00000, 1'b1);
    cfg_set(1'b1, 3, 7);
    cyc("t4_accept_ch3", 5'b00000, 5'b00000, 1'b0);
    cfg_set(1'b0, 0, 0);
    cyc("t4_apply_ch3", 5'b00000, 5'b00000, 1'b1);
    ch_en = 5'b00001;
    for (int j = 0; j < 2; j++) begin
      c = '0; s = '0;
      c[0] = hi(j, 3); s[0] = (j == 0);
      cyc("t4_ch0_alone", c, s, 1'b1);
    end
    ch_en = 5'b01001;
    for (int j = 0; j < 3; j++) begin
      p0 = (2 + j) % 3;
      p3 = j % 7;
      c = '0; s = '0;
      c[0] = hi(p0, 3); s[0] = (p0 == 0);
      c[3] = hi(p3, 7); s[3] = (p3 == 0);
      cyc("t4_skewed", c, s, 1'b1);
    end
    sync_req = 1'b1;
    cyc("t4_sync", 5'b01001, 5'b01001, 1'b1);
    sync_req = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      p0 = k % 3;
      p3 = k % 7;
      c = '0; s = '0;
      c[0] = hi(p0, 3); s[0] = (p0 == 0);
      c[3] = hi(p3, 7); s[3] = (p3 == 0);
      cyc("t4_aligned", c, s, 1'b1);
    end

    // T5: async reset with a request pending and mid-count
    cfg_set(1'b1, 3, 4);
    cyc("t5_accept", 5'b01001, 5'b00000, 1'b0);
    cfg_set(1'b0, 0, 0);
    #4 rst_n = 1'b0;
    #1 compare("t5_async_reset", z);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c = '0; c[0] = (k % 2 == 0); c[3] = (k % 2 == 0);
      cyc("t5_reverted_div2", c, c, 1'b1);
    end

    // T6: disable a channel with a pending update to it
    cfg_set(1'b1, 0, 3);
    cyc("t6_accept_on_wrap", 5'b01001, 5'b01001, 1'b0);
    cfg_set(1'b0, 0, 0);
    ch_en = 5'b01000;
    cyc("t6_apply_disabled", 5'b00000, 5'b00000, 1'b1);
    ch_en = 5'b01001;
    for (int j = 0; j < 6; j++) begin
      c = '0; s = '0;
      c[0] = hi(j % 3, 3); s[0] = (j % 3 == 0);
      c[3] = ((8 + j) % 2 == 0); s[3] = c[3];
      cyc("t6_reenabled", c, s, 1'b1);
    end

    @(posedge sys_clk);
    #5;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
